neuron_mac_seq: RTL and testbench

- Sequencer and multiply-accumulate stage that sits directly downstream of a neuron weight ROM.
- Drives the ROM address and consumes its registered weight output.
- Pairs each weight with one streamed input sample, accumulates the signed 8.8 fixed-point dot product, then scales and saturates it.
- Emits one neuron output per `start` on a valid/ready interface.

---
 rtl/neuron_mac_seq.sv | 144 ++++++++++++++
 tb/tb_neuron_mac_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// Weight-ROM sequencer and signed 8.8 multiply-accumulate neuron with saturating output.
// Optional ReLU activation when NEURON_MAC_RELU_EN is defined.
module neuron_mac_seq #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int N_INPUTS  = 10,
    parameter int BASE_ADDR = 1,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic              x_valid,
    output logic              x_ready,
    input  logic [DATA_W-1:0] x_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [DATA_W-1:0] y_data,
    output logic              done
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_ACT  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [2:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        x_q, x_d;
    logic [DATA_W-1:0]        y_data_q, y_data_d;
    logic                     y_valid_q, y_valid_d;
    logic                     done_q, done_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [DATA_W-1:0]   sat;
    logic [DATA_W-1:0]          act_result;

    assign prod    = $signed(x_q) * $signed(rom_dout);
    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        sat = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end
    end

`ifdef NEURON_MAC_RELU_EN
    assign act_result = sat[DATA_W-1] ? '0 : sat;
`else
    assign act_result = sat;
`endif

    // Address follows idx directly so it is already stable when REQ is entered.
    assign rom_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
    assign busy     = (state_q != S_IDLE);
    assign x_ready  = (state_q == S_REQ);
    assign y_valid  = y_valid_q;
    assign y_data   = y_data_q;
    assign done     = done_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (x_valid) begin
                    x_d     = x_data;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
                if (idx_q == IDX_W'(N_INPUTS-1)) begin
                    state_d = S_ACT;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_REQ;
                end
            end
            S_ACT: begin
                y_data_d  = act_result;
                y_valid_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    done_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed testbench for neuron_mac_seq with a 1-cycle registered weight ROM model.
// Expects NEURON_MAC_RELU_EN to be defined identically for bench and design.
module tb_neuron_mac_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic [15:0] rom_addr;
    logic [15:0] rom_dout;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] x_data;
    logic        y_valid;
    logic        y_ready;
    logic [15:0] y_data;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    neuron_mac_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_data   (x_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weights 1.0..6.0 at addresses 1..6, zero elsewhere.
    function automatic logic [15:0] wt(input logic [15:0] a);
        if (a >= 16'd1 && a <= 16'd6) return {a[7:0], 8'h00};
        return 16'h0000;
    endfunction

    always @(posedge clk) rom_dout <= wt(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feed up to n_elem samples; with full=1 also collect the result.
    task automatic run_neuron(input string name, input logic [15:0] xs, input bit gaps,
                              input int yhold, input bit spam, input int n_elem,
                              input bit full, output logic [15:0] y, output int lat);
        int c0;
        int tries;
        logic [15:0] held;
        y   = 16'hxxxx;
        lat = -1;
        @(negedge clk);
        y_ready = (yhold == 0);
        start   = 1'b1;
        c0      = cyc;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < n_elem; i++) begin
            if (gaps) begin
                x_valid = 1'b0;
                for (int g = 0; g <= (i % 3); g++) begin
                    if (spam && i == 3 && g == 0) start = 1'b1;
                    if (x_ready) chk({name, "_addr_stall"}, 32'(rom_addr), 32'(1 + i));
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            x_valid = 1'b1;
            x_data  = xs;
            tries   = 0;
            while (!x_ready && tries < 50) begin
                @(negedge clk);
                tries++;
            end
            chk({name, "_x_ready"}, 32'(x_ready), 32'd1);
            chk({name, "_addr"}, 32'(rom_addr), 32'(1 + i));
            if (i < n_elem - 1 || full) begin
                @(negedge clk);
                x_valid = 1'b0;
            end
        end
        if (!full) return;
        tries = 0;
        while (!y_valid && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        lat = cyc - c0;
        chk({name, "_y_valid"}, 32'(y_valid), 32'd1);
        held = y_data;
        for (int h = 0; h < yhold; h++) begin
            if (spam && h == 1) start = 1'b1;
            chk({name, "_hold_valid"}, 32'(y_valid), 32'd1);
            chk({name, "_hold_data"}, 32'(y_data), 32'(held));
            chk({name, "_hold_done"}, 32'(done), 32'd0);
            @(negedge clk);
            start = 1'b0;
        end
        y = y_data;
        y_ready = 1'b1;
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd1);
        chk({name, "_y_valid_clr"}, 32'(y_valid), 32'd0);
        @(negedge clk);
        chk({name, "_done_clr"}, 32'(done), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
        $display("run %s x=%h y=%h latency=%0d", name, xs, y, lat);
    endtask

    logic [15:0] y;
    int          lat;
    logic [15:0] neg_exp;

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        x_valid = 1'b0;
        x_data  = '0;
        y_ready = 1'b1;
`ifdef NEURON_MAC_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hEB00;
`endif
        repeat (3) @(negedge clk);
        chk("rst_addr",    32'(rom_addr), 32'd1);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_x_ready", 32'(x_ready),  32'd0);
        chk("rst_y_valid", 32'(y_valid),  32'd0);
        chk("rst_y_data",  32'(y_data),   32'd0);
        chk("rst_done",    32'(done),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_neuron("ones", 16'h0100, 1'b0, 0, 1'b0, 10, 1'b1, y, lat);
        chk("ones_y", 32'(y), 32'h1500);
        chk("ones_latency", 32'(lat), 32'd22);

        run_neuron("max", 16'h7FFF, 1'b0, 0, 1'b0, 10, 1'b1, y, lat);
        chk("max_y", 32'(y), 32'h7FFF);

        run_neuron("neg", 16'hFF00, 1'b0, 0, 1'b0, 10, 1'b1, y, lat);
        chk("neg_y", 32'(y), 32'(neg_exp));

        run_neuron("stall", 16'h0100, 1'b1, 5, 1'b1, 10, 1'b1, y, lat);
        chk("stall_y", 32'(y), 32'h1500);

        // Abort during element 4 while waiting in REQ.
        run_neuron("abort", 16'h0300, 1'b0, 0, 1'b0, 4, 1'b0, y, lat);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_addr",    32'(rom_addr), 32'd1);
        chk("abort_busy",    32'(busy),     32'd0);
        chk("abort_x_ready", 32'(x_ready),  32'd0);
        chk("abort_y_valid", 32'(y_valid),  32'd0);
        chk("abort_y_data",  32'(y_data),   32'd0);
        chk("abort_done",    32'(done),     32'd0);
        x_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_y_valid", 32'(y_valid), 32'd0);
        chk("abort_idle",       32'(busy),    32'd0);
        $display("run abort rst during element 4");

        run_neuron("after", 16'h0100, 1'b0, 0, 1'b0, 10, 1'b1, y, lat);
        chk("after_y", 32'(y), 32'h1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
